// File: rtl/flash_read_master.sv
// Avalon-MM burst read master for the on-chip flash data port.
// Fetches a run of words in credit-limited pipelined bursts and streams them out through a FIFO.
module flash_read_master #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic [ADDR_W-1:0] avm_addr,
  output logic              avm_read,
  output logic [2:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  // Handshakes: a burst transfers on an edge with avm_read=1 and avm_waitrequest=0;
  // a stream word transfers on an edge with out_valid=1 and out_ready=1.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              done_next;
  logic [ADDR_W-1:0] addr_q, issue_left, recv_left;
  logic [CW-1:0]     inflight, fifo_count, count_next, credit;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [2:0]        burst;
  logic              accept, push, pop;

  // Credit only grows while a burst is stalled (a push trades one inflight for one
  // FIFO entry), so the combinational request stays stable across waitrequest.
  always_comb begin
    burst          = (issue_left >= ADDR_W'(MAX_BURST)) ? 3'(MAX_BURST) : issue_left[2:0];
    credit         = CW'(FIFO_DEPTH) - fifo_count - inflight;
    avm_read       = (state == ISSUE) && (credit >= CW'(burst));
    avm_burstcount = (state == ISSUE) ? burst : 3'd0;
    accept         = avm_read && !avm_waitrequest;
    push           = avm_readdatavalid && (recv_left != '0);
    pop            = out_valid && out_ready;
    count_next     = fifo_count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_len != '0) state_next = ISSUE;
          else               done_next  = 1'b1;
        end
      end
      ISSUE:   if (accept && (issue_left == ADDR_W'(burst))) state_next = COLLECT;
      COLLECT: if (push && (recv_left == ADDR_W'(1))) state_next = DRAIN;
      DRAIN: begin
        if (count_next == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cmd_done <= 1'b0;
    end else begin
      state    <= state_next;
      cmd_done <= done_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      issue_left <= '0;
      recv_left  <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (state == IDLE && cmd_start && cmd_len != '0) begin
        addr_q     <= cmd_addr;
        issue_left <= cmd_len;
        recv_left  <= cmd_len;
      end else begin
        if (accept) begin
          addr_q     <= addr_q + ADDR_W'(burst);
          issue_left <= issue_left - ADDR_W'(burst);
        end
        if (push) recv_left <= recv_left - ADDR_W'(1);
      end
      inflight   <= inflight + (accept ? CW'(burst) : '0) - CW'(push);
      fifo_count <= count_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  assign avm_addr  = addr_q;
  assign cmd_busy  = (state != IDLE);
  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rd_ptr];
  assign dbg_state = state;

endmodule

// File: tb/tb_flash_read_master.sv
// Bench for flash_read_master: a randomized flash slave, a burst/data reference model
// computed from address arithmetic, and one task per scenario.
module tb_flash_read_master;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_start = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              cmd_busy, cmd_done;
  logic [ADDR_W-1:0] avm_addr;
  logic              avm_read;
  logic [2:0]        avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        dbg_state;

  always #5 clock = ~clock;

  flash_read_master dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .avm_addr(avm_addr), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [ADDR_W-1:0] exp_ba[$], got_ba[$], pend_a[$];
  logic [2:0]        exp_bc[$], got_bc[$];
  int pend_rc[$];
  int cyc = 0;
  int ready_mode = 1, wait_mode = 0, lat_mode = 0, stall_req = 0, done_cnt = 0;
  int first_read_cyc, first_acc_cyc, first_rdv_cyc, first_ov_cyc;
  logic [31:0] seed;

  // Flash contents: a fixed hash of the word address, plus the known word at 0x10.
  function automatic logic [31:0] flash_word(input logic [ADDR_W-1:0] a);
    if (a == 17'h00010) return 32'hDEADBEEF;
    return ({15'd0, a} * 32'h9E3779B1) ^ seed;
  endfunction

  // Reference: bursts are consecutive min(4, remaining) chunks; data is the word run.
  task automatic model_cmd(input logic [ADDR_W-1:0] a, input int len);
    int left = len;
    logic [ADDR_W-1:0] p = a;
    for (int i = 0; i < len; i++) exp_q.push_back(flash_word(a + ADDR_W'(i)));
    while (left > 0) begin
      int b = (left > 4) ? 4 : left;
      exp_ba.push_back(p);
      exp_bc.push_back(3'(b));
      p = p + ADDR_W'(b);
      left -= b;
    end
  endtask

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); exp_ba.delete(); exp_bc.delete();
    got_ba.delete(); got_bc.delete();
    done_cnt = 0;
    first_read_cyc = -1; first_acc_cyc = -1; first_rdv_cyc = -1; first_ov_cyc = -1;
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] a, input int len);
    @(negedge clock);
    cmd_start = 1'b1; cmd_addr = a; cmd_len = ADDR_W'(len);
    @(negedge clock);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clock);
  endtask

  // Flash slave and stream sink, evaluated mid-cycle for the next edge.
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; out_ready = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        pend_a.delete(); pend_rc.delete();
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        continue;
      end
      if (avm_read && first_read_cyc < 0) first_read_cyc = cyc;
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (cmd_done) done_cnt++;
      if (avm_read && stall_req > 0) begin
        avm_waitrequest = 1'b1;
        stall_req--;
      end else begin
        avm_waitrequest = (wait_mode != 0) && ($urandom_range(0, 2) == 0);
      end
      if (avm_read && !avm_waitrequest) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        got_ba.push_back(avm_addr);
        got_bc.push_back(avm_burstcount);
        for (int j = 0; j < int'(avm_burstcount); j++) begin
          pend_a.push_back(avm_addr + ADDR_W'(j));
          pend_rc.push_back(cyc + 2 + ((lat_mode != 0) ? int'($urandom_range(0, 3)) : 0));
        end
      end
      if (pend_a.size() > 0 && pend_rc[0] <= cyc && (lat_mode == 0 || $urandom_range(0, 3) != 0)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = flash_word(pend_a.pop_front());
        void'(pend_rc.pop_front());
        if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
      end
      out_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic test_reset();
    @(negedge clock);
    n_cmp++;
    if ({avm_read, avm_addr, avm_burstcount, cmd_busy, cmd_done, out_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: read=%b addr=%h bc=%0d busy=%b done=%b ov=%b, required all 0",
               avm_read, avm_addr, avm_burstcount, cmd_busy, cmd_done, out_valid);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_bursts();
    logic [ADDR_W-1:0] ta[3] = '{17'h00010, 17'h00100, 17'h1FFFC};
    int tl[3] = '{1, 10, 8};
    bit ok, bad;
    for (int t = 0; t < 3; t++) begin
      ready_mode = 1; wait_mode = 0; lat_mode = 0;
      clear_logs();
      model_cmd(ta[t], tl[t]);
      start_cmd(ta[t], tl[t]);
      n_cmp++;
      if (cmd_busy !== 1'b1 || avm_read !== 1'b1) begin
        n_fail++;
        $display("FAIL start_%0d: busy=%b read=%b, required 1/1", t, cmd_busy, avm_read);
      end
      wait_done(200, ok);
      n_cmp++;
      if (!ok || done_cnt != 1 || cmd_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_%0d: ok=%0d pulses=%0d busy=%b, required 1/1/0", t, ok, done_cnt, cmd_busy);
      end
      bad = (got_ba.size() != exp_ba.size());
      for (int i = 0; i < got_ba.size() && !bad; i++)
        if (got_ba[i] !== exp_ba[i] || got_bc[i] !== exp_bc[i]) bad = 1'b1;
      n_cmp++;
      if (bad) begin
        n_fail++;
        $display("FAIL bursts_%0d: %0d bursts seen first %h/%0d, required %0d first %h/%0d", t,
                 got_ba.size(), (got_ba.size() > 0) ? got_ba[0] : '0, (got_bc.size() > 0) ? got_bc[0] : '0,
                 exp_ba.size(), exp_ba[0], exp_bc[0]);
      end
      bad = (got_q.size() != exp_q.size());
      for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
      n_cmp++;
      if (bad) begin
        n_fail++;
        $display("FAIL data_%0d: %0d words seen first %h, required %0d first %h", t,
                 got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q.size(), exp_q[0]);
      end
      if (t == 0) begin
        n_cmp++;
        if (first_rdv_cyc - first_acc_cyc != 2 || first_ov_cyc - first_rdv_cyc != 1) begin
          n_fail++;
          $display("FAIL latency: acc->rdv=%0d rdv->valid=%0d, required 2/1",
                   first_rdv_cyc - first_acc_cyc, first_ov_cyc - first_rdv_cyc);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] a0;
    logic [2:0] c0;
    bit ok, bad;
    ready_mode = 1; wait_mode = 0; lat_mode = 0;
    clear_logs();
    model_cmd(17'h00400, 6);
    stall_req = 5;
    start_cmd(17'h00400, 6);
    a0 = avm_addr; c0 = avm_burstcount;
    bad = (avm_read !== 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (avm_read !== 1'b1 || avm_addr !== a0 || avm_burstcount !== c0) bad = 1'b1;
    end
    n_cmp++;
    if (bad || a0 !== 17'h00400 || c0 !== 3'd4) begin
      n_fail++;
      $display("FAIL stall_hold: read=%b addr=%h bc=%0d, required 1/00400/4 held", avm_read, a0, c0);
    end
    wait_done(200, ok);
    n_cmp++;
    if (first_acc_cyc - first_read_cyc != 5) begin
      n_fail++;
      $display("FAIL stall_accept: accepted %0d cycles after request, required 5", first_acc_cyc - first_read_cyc);
    end
    bad = !ok || (got_q.size() != exp_q.size()) || (got_ba.size() != exp_ba.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_data: done=%0d words=%0d bursts=%0d, required 1/%0d/%0d",
               ok, got_q.size(), got_ba.size(), exp_q.size(), exp_ba.size());
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a = ADDR_W'($urandom);
    int words = 0;
    bit ok, bad;
    ready_mode = 0; wait_mode = 0; lat_mode = 0;
    clear_logs();
    model_cmd(a, 20);
    start_cmd(a, 20);
    repeat (40) @(negedge clock);
    foreach (got_bc[i]) words += int'(got_bc[i]);
    n_cmp++;
    if (words != 8 || avm_read !== 1'b0 || out_valid !== 1'b1 || cmd_busy !== 1'b1 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL fifo_full: requested=%0d read=%b ov=%b busy=%b popped=%0d, required 8/0/1/1/0",
               words, avm_read, out_valid, cmd_busy, got_q.size());
    end
    ready_mode = 1;
    wait_done(300, ok);
    bad = !ok || (got_q.size() != exp_q.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    for (int i = 0; i < got_ba.size() && !bad; i++)
      if (i >= exp_ba.size() || got_ba[i] !== exp_ba[i] || got_bc[i] !== exp_bc[i]) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL resume: done=%0d words=%0d, required 1/%0d in order", ok, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    start_cmd(17'h00123, 0);
    n_cmp++;
    if (cmd_done !== 1'b1 || cmd_busy !== 1'b0 || avm_read !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done: done=%b busy=%b read=%b, required 1/0/0", cmd_done, cmd_busy, avm_read);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (cmd_done !== 1'b0 || got_ba.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_len_after: done=%b bursts=%0d pulses=%0d, required 0/0/1", cmd_done, got_ba.size(), done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [ADDR_W-1:0] a = ADDR_W'($urandom);
    bit ok, bad;
    ready_mode = 1; wait_mode = 0; lat_mode = 0;
    clear_logs();
    start_cmd(17'h00800, 12);
    for (int i = 0; i < 20 && got_ba.size() == 0; i++) @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({avm_read, avm_addr, avm_burstcount, cmd_busy, cmd_done, out_valid} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: read=%b addr=%h bc=%0d busy=%b done=%b ov=%b, required all 0",
               avm_read, avm_addr, avm_burstcount, cmd_busy, cmd_done, out_valid);
    end
    reset = 1'b0;
    @(negedge clock);
    clear_logs();
    model_cmd(a, 4);
    start_cmd(a, 4);
    wait_done(200, ok);
    bad = !ok || done_cnt != 1 || (got_q.size() != exp_q.size()) || (got_ba.size() != 1);
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    if (!bad && (got_ba[0] !== a || got_bc[0] !== 3'd4)) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL after_reset: done=%0d pulses=%0d words=%0d bursts=%0d, required 1/1/4/1",
               ok, done_cnt, got_q.size(), got_ba.size());
    end
  endtask

  task automatic test_random();
    bit ok, bad;
    for (int t = 0; t < 8; t++) begin
      logic [ADDR_W-1:0] a = ADDR_W'($urandom);
      int len = $urandom_range(1, 25);
      ready_mode = 2; wait_mode = 1; lat_mode = 1;
      clear_logs();
      model_cmd(a, len);
      start_cmd(a, len);
      wait_done(2000, ok);
      bad = !ok || done_cnt != 1 || (got_q.size() != exp_q.size()) || (got_ba.size() != exp_ba.size());
      for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
      for (int i = 0; i < got_ba.size() && !bad; i++)
        if (got_ba[i] !== exp_ba[i] || got_bc[i] !== exp_bc[i]) bad = 1'b1;
      n_cmp++;
      if (bad) begin
        n_fail++;
        $display("FAIL random_%0d addr=%h len=%0d: done=%0d pulses=%0d words=%0d bursts=%0d, required 1/1/%0d/%0d",
                 t, a, len, ok, done_cnt, got_q.size(), got_ba.size(), exp_q.size(), exp_ba.size());
      end
    end
  endtask

  initial begin
    seed = $urandom;
    clear_logs();
    repeat (3) @(posedge clock);
    test_reset();
    test_bursts();
    test_stall();
    test_backpressure();
    test_zero_len();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
